// File: rtl/lockstep_recovery_if.sv
// Result/commit bundle between the lockstep cores, the recovery controller and its observers.
interface lockstep_recovery_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              valid1;
  logic [DATA_W-1:0] result1;
  logic              valid2;
  logic [DATA_W-1:0] result2;
  logic              core_reset;
  logic              commit_valid;
  logic [DATA_W-1:0] commit_data;
  logic              error_pulse;
  logic              fatal;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output valid1, result1, valid2, result2,
    input  core_reset, commit_valid, commit_data, error_pulse, fatal, err_count
  );

  modport slave (
    input  valid1, result1, valid2, result2,
    output core_reset, commit_valid, commit_data, error_pulse, fatal, err_count
  );
endinterface

// File: rtl/lockstep_recovery_ctrl.sv
// Pairs lockstep core results, commits agreed values and sequences core reset/retry on faults.
//   state   | meaning
//   RUN     | no result held, waiting for either core
//   WAIT1   | core 1 result held, waiting for core 2
//   WAIT2   | core 2 result held, waiting for core 1
//   RECOVER | cores held in reset for RESET_CYCLES
//   FATAL   | retry budget exhausted, held until block reset
module lockstep_recovery_ctrl #(
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 16,
  parameter int RESET_CYCLES = 8,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lockstep_recovery_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int MW = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [MW-1:0] RETRY_MAX = MW'(MAX_RETRIES);

  typedef enum logic [2:0] {RUN, WAIT1, WAIT2, RECOVER, FATAL} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] held_q, held_d, cdata_q, cdata_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [MW-1:0]     retry_q, retry_d;
  logic [CNT_W-1:0]  errc_q, errc_d;
  logic              commit_q, commit_d, err_q, err_d, crst_q, crst_d, fatal_q, fatal_d;
  logic              ok, fail;
  logic [DATA_W-1:0] ok_val;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    tmo_d    = tmo_q;
    rcnt_d   = rcnt_q;
    retry_d  = retry_q;
    errc_d   = errc_q;
    cdata_d  = cdata_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    ok       = 1'b0;
    fail     = 1'b0;
    ok_val   = held_q;

    case (state_q)
      RUN: begin
        if (bus.valid1 && bus.valid2) begin
          ok_val = bus.result1;
          if (bus.result1 == bus.result2) ok = 1'b1;
          else                            fail = 1'b1;
        end else if (bus.valid1) begin
          held_d  = bus.result1;
          tmo_d   = '0;
          state_d = WAIT1;
        end else if (bus.valid2) begin
          held_d  = bus.result2;
          tmo_d   = '0;
          state_d = WAIT2;
        end
      end
      // tmo_q counts completed wait cycles, so the partner is still accepted on cycle TIMEOUT
      WAIT1: begin
        if (bus.valid2) begin
          if (bus.result2 == held_q) ok = 1'b1;
          else                       fail = 1'b1;
        end else if (bus.valid1 || tmo_q == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT2: begin
        if (bus.valid1) begin
          if (bus.result1 == held_q) ok = 1'b1;
          else                       fail = 1'b1;
        end else if (bus.valid2 || tmo_q == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RECOVER: begin
        if (rcnt_q == RCNT_LAST) state_d = RUN;
        else                     rcnt_d  = rcnt_q + 1'b1;
      end
      FATAL:   ;
      default: state_d = RUN;
    endcase

    if (ok) begin
      commit_d = 1'b1;
      cdata_d  = ok_val;
      retry_d  = '0;
      state_d  = RUN;
    end
    if (fail) begin
      err_d   = 1'b1;
      if (errc_q != '1) errc_d = errc_q + 1'b1;
      retry_d = retry_q + 1'b1;
      rcnt_d  = '0;
      state_d = (retry_d == RETRY_MAX) ? FATAL : RECOVER;
    end

    crst_d  = (state_d == RECOVER) || (state_d == FATAL);
    fatal_d = (state_d == FATAL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      held_q   <= '0;
      cdata_q  <= '0;
      tmo_q    <= '0;
      rcnt_q   <= '0;
      retry_q  <= '0;
      errc_q   <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      crst_q   <= 1'b0;
      fatal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      cdata_q  <= cdata_d;
      tmo_q    <= tmo_d;
      rcnt_q   <= rcnt_d;
      retry_q  <= retry_d;
      errc_q   <= errc_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      crst_q   <= crst_d;
      fatal_q  <= fatal_d;
    end
  end

  assign bus.core_reset   = crst_q;
  assign bus.commit_valid = commit_q;
  assign bus.commit_data  = cdata_q;
  assign bus.error_pulse  = err_q;
  assign bus.fatal        = fatal_q;
  assign bus.err_count    = errc_q;

endmodule

// File: tb/tb_lockstep_recovery_ctrl.sv
// Vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_lockstep_recovery_ctrl;
  localparam int DW = 32, TMO = 16, RC = 8, MR = 3, CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0, n_pass = 0;

  lockstep_recovery_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  lockstep_recovery_ctrl #(
    .DATA_W(DW), .TIMEOUT(TMO), .RESET_CYCLES(RC), .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v1; logic [31:0] r1; logic v2; logic [31:0] r2;
    logic cv; logic [31:0] cd; logic ep; logic cr; logic f; logic [7:0] cnt;
  } vec_t;

  vec_t tbl[15];

  // behavioural model: which core's result is pending, how long it has waited,
  // how many reset cycles remain, and whether the controller is dead
  int          m_held, m_waited, m_rec_left, m_retries, m_errs;
  bit          m_fatal;
  logic [31:0] m_val, m_cdata;
  logic        e_cv, e_ep;

  task automatic chk_out(string nm, logic cr, logic cv, logic ep, logic f,
                         logic [7:0] cnt, logic [31:0] cd);
    logic [43:0] act, exp;
    act = {bus.core_reset, bus.commit_valid, bus.error_pulse, bus.fatal, bus.err_count, bus.commit_data};
    exp = {cr, cv, ep, f, cnt, cd};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got cr/cv/ep/fatal/cnt/data=%h expected %h", nm, act, exp);
  endtask

  task automatic drive(logic v1, logic [31:0] r1, logic v2, logic [31:0] r2);
    bus.valid1 = v1; bus.result1 = r1; bus.valid2 = v2; bus.result2 = r2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic model_reset();
    m_held = 0; m_waited = 0; m_rec_left = 0; m_retries = 0; m_errs = 0;
    m_fatal = 0; m_val = '0; m_cdata = '0; e_cv = 0; e_ep = 0;
  endtask

  task automatic do_reset();
    bus.valid1 = 0; bus.result1 = '0; bus.valid2 = 0; bus.result2 = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_step(logic v1, logic [31:0] r1, logic v2, logic [31:0] r2);
    bit fail, pv, sv;
    logic [31:0] pr;
    fail = 0; e_cv = 0; e_ep = 0;
    if (m_fatal) begin
    end else if (m_rec_left > 0) begin
      m_rec_left--;
    end else if (m_held == 0) begin
      if (v1 && v2) begin
        if (r1 == r2) begin e_cv = 1; m_cdata = r1; end
        else fail = 1;
      end else if (v1) begin m_held = 1; m_val = r1; m_waited = 0; end
      else if (v2)     begin m_held = 2; m_val = r2; m_waited = 0; end
    end else begin
      pv = (m_held == 1) ? v2 : v1;
      pr = (m_held == 1) ? r2 : r1;
      sv = (m_held == 1) ? v1 : v2;
      m_waited++;
      if (pv) begin
        if (pr == m_val) begin e_cv = 1; m_cdata = m_val; end
        else fail = 1;
      end else if (sv || m_waited == TMO) fail = 1;
      if (pv || fail) m_held = 0;
    end
    if (e_cv) m_retries = 0;
    if (fail) begin
      e_ep = 1;
      if (m_errs < 255) m_errs++;
      m_retries++;
      m_held = 0;
      if (m_retries == MR) m_fatal = 1;
      else m_rec_left = RC;
    end
  endtask

  task automatic recover_wait(logic [7:0] cnt, logic [31:0] cd);
    for (int i = 0; i < RC - 1; i++) begin
      idle();
      chk_out("recover_hold", 1, 0, 0, 0, cnt, cd);
    end
    idle();
    chk_out("recover_release", 0, 0, 0, 0, cnt, cd);
  endtask

  initial begin
    tbl[0]  = '{1, 32'hCAFE0001, 1, 32'hCAFE0001, 1, 32'hCAFE0001, 0, 0, 0, 0};
    tbl[1]  = '{1, 32'h10, 0, 32'h0, 0, 32'hCAFE0001, 0, 0, 0, 0};
    tbl[2]  = '{0, 32'h0,  0, 32'h0, 0, 32'hCAFE0001, 0, 0, 0, 0};
    tbl[3]  = '{0, 32'h0,  0, 32'h0, 0, 32'hCAFE0001, 0, 0, 0, 0};
    tbl[4]  = '{0, 32'h0,  1, 32'h10, 1, 32'h10, 0, 0, 0, 0};
    tbl[5]  = '{1, 32'h5,  1, 32'h7, 0, 32'h10, 1, 1, 0, 1};
    tbl[6]  = '{0, 32'h0,  0, 32'h0, 0, 32'h10, 0, 1, 0, 1};
    tbl[7]  = '{0, 32'h0,  0, 32'h0, 0, 32'h10, 0, 1, 0, 1};
    tbl[8]  = '{1, 32'h1,  1, 32'h2, 0, 32'h10, 0, 1, 0, 1};
    tbl[9]  = '{0, 32'h0,  0, 32'h0, 0, 32'h10, 0, 1, 0, 1};
    tbl[10] = '{1, 32'h3,  1, 32'h3, 0, 32'h10, 0, 1, 0, 1};
    tbl[11] = '{0, 32'h0,  0, 32'h0, 0, 32'h10, 0, 1, 0, 1};
    tbl[12] = '{0, 32'h0,  0, 32'h0, 0, 32'h10, 0, 1, 0, 1};
    tbl[13] = '{0, 32'h0,  0, 32'h0, 0, 32'h10, 0, 0, 0, 1};
    tbl[14] = '{1, 32'h22, 1, 32'h22, 1, 32'h22, 0, 0, 0, 1};

    do_reset();
    chk_out("reset_state", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v1, tbl[i].r1, tbl[i].v2, tbl[i].r2);
      chk_out($sformatf("vec%0d", i), tbl[i].cr, tbl[i].cv, tbl[i].ep, tbl[i].f, tbl[i].cnt, tbl[i].cd);
    end

    // timeout after TIMEOUT wait cycles, then partner accepted on wait cycle TIMEOUT
    do_reset();
    drive(1, 32'hAB, 0, 0);
    for (int i = 1; i < TMO; i++) begin
      idle();
      chk_out("timeout_waiting", 0, 0, 0, 0, 0, 0);
    end
    idle();
    chk_out("timeout_fire", 1, 0, 1, 0, 1, 0);
    recover_wait(1, 0);
    drive(1, 32'h3C, 0, 0);
    for (int i = 1; i < TMO; i++) idle();
    chk_out("late_wait", 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 32'h3C);
    chk_out("late_partner_commit", 0, 1, 0, 0, 1, 32'h3C);

    // retry budget exhaustion
    do_reset();
    drive(1, 32'h5, 1, 32'h7);
    chk_out("fatal_err1", 1, 0, 1, 0, 1, 0);
    recover_wait(1, 0);
    drive(1, 32'h5, 1, 32'h7);
    chk_out("fatal_err2", 1, 0, 1, 0, 2, 0);
    recover_wait(2, 0);
    drive(1, 32'h5, 1, 32'h7);
    chk_out("fatal_enter", 1, 0, 1, 1, 3, 0);
    for (int i = 0; i < 10; i++) idle();
    drive(1, 32'h44, 1, 32'h44);
    chk_out("fatal_no_commit", 1, 0, 0, 1, 3, 0);
    rst = 1'b1;
    #1;
    chk_out("fatal_async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // commit clears the retry counter; reset aborts recovery at once
    model_reset();
    drive(1, 32'h5, 1, 32'h7);
    chk_out("retry_err1", 1, 0, 1, 0, 1, 0);
    recover_wait(1, 0);
    drive(1, 32'h99, 1, 32'h99);
    chk_out("retry_commit", 0, 1, 0, 0, 1, 32'h99);
    drive(1, 32'h5, 1, 32'h7);
    chk_out("retry_err2", 1, 0, 1, 0, 2, 32'h99);
    recover_wait(2, 32'h99);
    drive(1, 32'h5, 1, 32'h7);
    chk_out("retry_no_fatal", 1, 0, 1, 0, 3, 32'h99);
    idle(); idle(); idle();
    rst = 1'b1;
    #1;
    chk_out("recover_async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized run against the model
    model_reset();
    begin
      logic [31:0] base;
      logic        v1, v2;
      logic [31:0] r1, r2;
      base = $urandom;
      for (int c = 0; c < 3000; c++) begin
        if (c % 40 == 0) base = $urandom;
        if ((m_fatal && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
          do_reset();
          chk_out("rand_reset", 0, 0, 0, 0, 0, 0);
        end else begin
          v1 = ($urandom_range(0, 2) == 0);
          v2 = ($urandom_range(0, 2) == 0);
          r1 = base ^ 32'($urandom_range(0, 1));
          r2 = ($urandom_range(0, 3) == 0) ? $urandom : (base ^ 32'($urandom_range(0, 1)));
          drive(v1, r1, v2, r2);
          model_step(v1, r1, v2, r2);
          chk_out($sformatf("rand_c%0d", c), m_fatal || (m_rec_left > 0), e_cv, e_ep,
                  m_fatal, 8'(m_errs), m_cdata);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
